data_wb_arbiter: RTL and testbench
==================================

# data_wb_arbiter

Two-master, one-slave Wishbone (pipelined, with stall) arbiter that shares the data-memory bus between the core's data port (master 0) and a secondary master such as DMA or debug (master 1). It sits between the core wrapper's data Wishbone port and the data-memory/peripheral interconnect. It provides round-robin arbitration, locks ownership for a whole cycle, and adds a bus-timeout watchdog that converts a hung access into an error response.

## Interface
- TIMEOUT_CYCLES, 255: consecutive cycles with an access outstanding and no ack/err before abort; legal range 1..65535.
- OUTST_W, 2: width of the outstanding-access counter (saturates at 2^OUTST_W-1).
- data_wb_clk_i  in  1  clock; all logic on its rising edge.
- data_wb_rst_i  in  1  reset, asynchronous, active-high.
- mN_cyc_i, mN_stb_i, mN_we_i  in  1  master N (N=0,1) cycle, strobe, write enable.
- mN_adr_i, mN_dat_i  in  32  master N address, write data.
- mN_sel_i  in  4  master N byte select.
- mN_stall_o, mN_ack_o, mN_err_o  out  1  to master N.
- mN_dat_o  out  32  read data to master N.
- s_cyc_o, s_stb_o, s_we_o  out  1  to slave.
- s_adr_o, s_dat_o  out  32  to slave.
- s_sel_o  out  4  to slave.
- s_stall_i, s_ack_i, s_err_i  in  1  from slave.
- s_dat_i  in  32  read data from slave.
- gnt_o  out  2  one-hot current owner; 00 when idle.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, OWN, ABORT. Registers: state, owner (1 bit), last (last granted, reset 1), outst count, timer.
- IDLE: if any mN_cyc_i is high, select the winner combinationally in the same cycle. With one requester it wins. With both, the winner is the master other than `last`. Set owner=winner, last=winner, next state OWN. The winner's request passes through to the slave in that same cycle (zero-latency grant).
- OWN: the slave side is a mux of owner's signals. s_cyc_o=own cyc. s_stb_o=own stb. we/adr/dat/sel are passed through. Owner receives s_stall_i/ack/err/dat.
- Non-owner: stall_o=1, ack_o=0, err_o=0, dat_o=0.
- OWN→IDLE when owner's cyc_i=0. s_cyc_o drops in that cycle. A new grant can be issued on the next cycle; no same-cycle handover.
- outst: +1 on s_stb_o&~s_stall_i, −1 on s_ack_i|s_err_i. Both in the same cycle leaves it unchanged. Clears on leaving OWN.
- Accepting a strobe while outst is saturated is prevented by forcing the owner's stall_o=1.
- Timer: runs only while outst>0. Clears on any ack/err or when outst=0.
- When timer reaches TIMEOUT_CYCLES−1 without ack/err:
  - pulse owner err_o and timeout_o for one cycle;
  - clear outst;
  - go to ABORT.
- ABORT: s_cyc_o=s_stb_o=0. Owner sees stall=1, ack=0, err=0. Late slave ack/err is discarded. ABORT→IDLE when owner's cyc_i=0.
- Slave err with no timeout is forwarded transparently, and ownership is unchanged.

## Timing
- Reset values: all outputs 0, except m0/m1 stall_o=1 while state=IDLE with no request. state=IDLE, last=1 (so master 0 wins the first tie), outst=0, timer=0.
- Reset asserted mid-access drops s_cyc_o/s_stb_o immediately (asynchronously). No ack/err is delivered.
- Grant latency is 0 cycles from cyc_i in IDLE. A request blocked by the other owner waits until that owner's cyc falls, plus 1 cycle.
- Ack/err/dat to the owner are combinational from the slave (0-cycle added latency).
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last accept/ack event with outst>0.
- Both masters raise cyc in the same IDLE cycle: grant alternates on successive arbitrations (0,1,0,1...).

## Structure
- Package data_wb_arb_pkg: state enum (IDLE/OWN/ABORT) and localparams M_CORE=0, M_AUX=1.
- One sub-module, data_wb_arb_timer: the outstanding counter plus watchdog, with outputs `expired` and `full`. The top level holds the FSM and muxes.

## Test plan
- Core-only read: m0 cyc/stb for 1 cycle, adr=0x100, slave acks 2 cycles later with 0xDEADBEEF. Expect m0_ack_o and m0_dat_o=0xDEADBEEF, gnt_o=01, m1_stall_o=1 throughout.
- Simultaneous requests from reset, each doing 3 back-to-back cycles. Expect grants 0,1,0,1,0,1 and never two owners at once.
- m1 owns with slave stalling 5 cycles. Expect m0 to be stalled until m1 cyc falls, then granted the next cycle.
- TIMEOUT_CYCLES=8, slave never acks. Expect m0_err_o and timeout_o high exactly 8 cycles after accept, s_cyc_o=0 in ABORT, and a late s_ack_i not forwarded.
- Slave err on write (we=1, sel=0xF): m1_err_o forwarded the same cycle, timeout_o=0, and ownership kept until cyc falls.
- Assert data_wb_rst_i mid-access: s_cyc_o=0 immediately, gnt_o=00, and the next tie goes to master 0.

Source files
------------

// File: rtl/data_wb_arb_pkg.sv
// rtl/data_wb_arb_pkg.sv - shared state encoding and master indices for the data bus arbiter
package data_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam logic M_CORE = 1'b0;
    localparam logic M_AUX  = 1'b1;

endpackage

// File: rtl/data_wb_arb_timer.sv
// rtl/data_wb_arb_timer.sv - outstanding-access counter and bus watchdog for the data bus arbiter
module data_wb_arb_timer
    import data_wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OUTST_W        = 2
) (
    input  logic data_wb_clk_i,
    input  logic data_wb_rst_i,
    input  logic active,
    input  logic accept,
    input  logic resp,
    output logic expired,
    output logic full
);

    localparam logic [OUTST_W-1:0] OUTST_MAX  = '1;
    localparam logic [15:0]        TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [OUTST_W-1:0] outst;
    logic [15:0]        timer;
    logic               busy;

    assign busy    = (outst != '0);
    assign full    = (outst == OUTST_MAX);
    assign expired = active && busy && !resp && (timer == TIMER_LAST);

    // Any accept or response restarts the watchdog; it only counts silent cycles.
    always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
        if (data_wb_rst_i) begin
            outst <= '0;
            timer <= '0;
        end else if (!active || expired) begin
            outst <= '0;
            timer <= '0;
        end else begin
            if (accept && !resp && !full) begin
                outst <= outst + OUTST_W'(1);
            end else if (resp && !accept && busy) begin
                outst <= outst - OUTST_W'(1);
            end
            if (busy && !accept && !resp) begin
                timer <= timer + 16'd1;
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: rtl/data_wb_arbiter.sv
// rtl/data_wb_arbiter.sv - round-robin two-master pipelined Wishbone arbiter with bus watchdog
module data_wb_arbiter
    import data_wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OUTST_W        = 2
) (
    input  logic        data_wb_clk_i,
    input  logic        data_wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic        m0_stall_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic        m1_stall_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_stall_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    arb_state_t state, state_n;
    logic       owner, owner_n;
    logic       last, last_n;
    logic       winner;
    logic       cur;
    logic       any_req;
    logic       cur_cyc, cur_stb, cur_we;
    logic [31:0] cur_adr, cur_dat;
    logic [3:0] cur_sel;
    logic       bus_on;
    logic       expired;
    logic       full;

    assign any_req = m0_cyc_i | m1_cyc_i;

    always_comb begin
        winner = M_CORE;
        if (m0_cyc_i && m1_cyc_i) begin
            winner = ~last;
        end else if (m1_cyc_i) begin
            winner = M_AUX;
        end
    end

    // In IDLE the winner is routed straight through so a grant costs no cycle.
    assign cur     = (state == IDLE) ? winner : owner;
    assign cur_cyc = cur ? m1_cyc_i : m0_cyc_i;
    assign cur_stb = cur ? m1_stb_i : m0_stb_i;
    assign cur_we  = cur ? m1_we_i  : m0_we_i;
    assign cur_adr = cur ? m1_adr_i : m0_adr_i;
    assign cur_dat = cur ? m1_dat_i : m0_dat_i;
    assign cur_sel = cur ? m1_sel_i : m0_sel_i;

    // Reset gates the bus combinationally so an asserted reset drops cyc at once.
    assign bus_on = !data_wb_rst_i && (state != ABORT) && cur_cyc;

    assign s_cyc_o   = bus_on;
    assign s_stb_o   = bus_on && cur_stb && !full;
    assign s_we_o    = bus_on && cur_we;
    assign s_adr_o   = bus_on ? cur_adr : '0;
    assign s_dat_o   = bus_on ? cur_dat : '0;
    assign s_sel_o   = bus_on ? cur_sel : '0;
    assign timeout_o = expired;

    data_wb_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .OUTST_W        (OUTST_W)
    ) u_timer (
        .data_wb_clk_i (data_wb_clk_i),
        .data_wb_rst_i (data_wb_rst_i),
        .active        (bus_on),
        .accept        (s_stb_o && !s_stall_i),
        .resp          (s_ack_i || s_err_i),
        .expired       (expired),
        .full          (full)
    );

    always_comb begin
        m0_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_dat_o   = '0;
        m1_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_dat_o   = '0;
        if (bus_on) begin
            if (cur == M_CORE) begin
                m0_stall_o = s_stall_i || full;
                m0_ack_o   = s_ack_i;
                m0_err_o   = s_err_i || expired;
                m0_dat_o   = s_dat_i;
            end else begin
                m1_stall_o = s_stall_i || full;
                m1_ack_o   = s_ack_i;
                m1_err_o   = s_err_i || expired;
                m1_dat_o   = s_dat_i;
            end
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        if (!data_wb_rst_i && (state != IDLE || any_req)) begin
            gnt_o[cur] = 1'b1;
        end
    end

    always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
        if (data_wb_rst_i) begin
            state <= IDLE;
            owner <= M_CORE;
            last  <= M_AUX;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = OWN;
                    owner_n = winner;
                    last_n  = winner;
                end
            end
            OWN: begin
                if (!cur_cyc) begin
                    state_n = IDLE;
                end else if (expired) begin
                    state_n = ABORT;
                end
            end
            ABORT: begin
                if (!cur_cyc) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_wb_arbiter.sv
// tb/tb_data_wb_arbiter.sv - self-checking bench for data_wb_arbiter against a transaction-level model
module tb_data_wb_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_stall_o, m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic        m1_stall_o, m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_stall_i, s_ack_i, s_err_i;
    logic [31:0] s_dat_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;
    int last_model = 1;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] adr_pool [4] = '{32'h0000_0104, 32'h0000_0200, 32'h0000_0204, 32'h0000_0300};

    data_wb_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .OUTST_W        (2)
    ) dut (
        .data_wb_clk_i (clk),
        .data_wb_rst_i (rst),
        .m0_cyc_i   (m0_cyc_i),
        .m0_stb_i   (m0_stb_i),
        .m0_we_i    (m0_we_i),
        .m0_adr_i   (m0_adr_i),
        .m0_dat_i   (m0_dat_i),
        .m0_sel_i   (m0_sel_i),
        .m0_stall_o (m0_stall_o),
        .m0_ack_o   (m0_ack_o),
        .m0_err_o   (m0_err_o),
        .m0_dat_o   (m0_dat_o),
        .m1_cyc_i   (m1_cyc_i),
        .m1_stb_i   (m1_stb_i),
        .m1_we_i    (m1_we_i),
        .m1_adr_i   (m1_adr_i),
        .m1_dat_i   (m1_dat_i),
        .m1_sel_i   (m1_sel_i),
        .m1_stall_o (m1_stall_o),
        .m1_ack_o   (m1_ack_o),
        .m1_err_o   (m1_err_o),
        .m1_dat_o   (m1_dat_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_we_o     (s_we_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_sel_o    (s_sel_o),
        .s_stall_i  (s_stall_i),
        .s_ack_i    (s_ack_i),
        .s_err_i    (s_err_i),
        .s_dat_i    (s_dat_i),
        .gnt_o      (gnt_o),
        .timeout_o  (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
            check("ack_without_gnt", 32'((m0_ack_o && !gnt_o[0]) || (m1_ack_o && !gnt_o[1])), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        end
        return r;
    endfunction

    // Round robin in words: a lone requester wins; on a tie the master not served last wins.
    function automatic int model_pick(input logic [1:0] mask);
        int w;
        if (mask == 2'b11) w = (last_model == 0) ? 1 : 0;
        else w = mask[1] ? 1 : 0;
        last_model = w;
        return w;
    endfunction

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
        end
    endtask

    task automatic set_stb(input int m, input logic v);
        if (m == 0) m0_stb_i = v; else m1_stb_i = v;
    endtask

    task automatic set_cyc(input int m, input logic v);
        if (m == 0) m0_cyc_i = v; else m1_cyc_i = v;
    endtask

    function automatic logic get_stall(input int m);
        return (m == 0) ? m0_stall_o : m1_stall_o;
    endfunction

    function automatic logic get_ack(input int m);
        return (m == 0) ? m0_ack_o : m1_ack_o;
    endfunction

    function automatic logic get_err(input int m);
        return (m == 0) ? m0_err_o : m1_err_o;
    endfunction

    function automatic logic [31:0] get_dat(input int m);
        return (m == 0) ? m0_dat_o : m1_dat_o;
    endfunction

    // Master m's request is already driven; expects m to own the bus this very cycle.
    task automatic run_access(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int stalls, input int lat,
                              input logic give_err, input int hold);
        logic [31:0] oh;
        logic [31:0] acc_adr;
        logic [31:0] exp_rd;
        oh = (m == 0) ? 32'd1 : 32'd2;
        for (int s = 0; s <= stalls; s++) begin
            s_stall_i = (s < stalls);
            @(negedge clk);
            check("gnt_req", 32'(gnt_o), oh);
            check("s_cyc", 32'(s_cyc_o), 32'd1);
            check("s_stb", 32'(s_stb_o), 32'd1);
            check("s_adr", s_adr_o, adr);
            check("s_we", 32'(s_we_o), 32'(we));
            check("s_sel", 32'(s_sel_o), 32'(sel));
            if (we) check("s_dat", s_dat_o, dat);
            check("stall_own", 32'(get_stall(m)), 32'(s < stalls));
            check("stall_other", 32'(get_stall(1 - m)), 32'd1);
            if (s < stalls) tick();
        end
        acc_adr = s_adr_o;
        if (we && !give_err) begin
            slv_mem[acc_adr] = merge(slv_rd(acc_adr), s_dat_o, s_sel_o);
            ref_mem[adr] = merge(ref_rd(adr), dat, sel);
        end
        exp_rd = ref_rd(adr);
        tick();
        set_stb(m, 1'b0);
        s_stall_i = 1'b0;
        for (int l = 1; l < lat; l++) begin
            @(negedge clk);
            check("ack_early", 32'(get_ack(m)), 32'd0);
            check("gnt_wait", 32'(gnt_o), oh);
            tick();
        end
        s_ack_i = !give_err;
        s_err_i = give_err;
        s_dat_i = slv_rd(acc_adr);
        @(negedge clk);
        check("ack", 32'(get_ack(m)), 32'(!give_err));
        check("err", 32'(get_err(m)), 32'(give_err));
        check("timeout_quiet", 32'(timeout_o), 32'd0);
        check("gnt_ack", 32'(gnt_o), oh);
        if (!we) check("rdata", get_dat(m), exp_rd);
        check("dat_other", get_dat(1 - m), 32'd0);
        check("ack_other", 32'(get_ack(1 - m) | get_err(1 - m)), 32'd0);
        tick();
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = '0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("gnt_hold", 32'(gnt_o), oh);
            check("cyc_hold", 32'(s_cyc_o), 32'd1);
            tick();
        end
        set_cyc(m, 1'b0);
        @(negedge clk);
        check("cyc_drop", 32'(s_cyc_o), 32'd0);
        check("stall_other_drop", 32'(get_stall(1 - m)), 32'd1);
        tick();
    endtask

    task automatic do_round(input logic [1:0] mask, input int win_stalls);
        logic [31:0] adr [2];
        logic [31:0] dat [2];
        logic        we  [2];
        logic [3:0]  sel [2];
        int w;
        int l;
        for (int i = 0; i < 2; i++) begin
            adr[i] = adr_pool[$urandom_range(0, 3)];
            dat[i] = $urandom;
            we[i]  = 1'($urandom_range(0, 1));
            sel[i] = 4'($urandom_range(1, 15));
            if (mask[i]) drive_m(i, 1'b1, 1'b1, we[i], adr[i], dat[i], sel[i]);
            else drive_m(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        end
        w = model_pick(mask);
        run_access(w, we[w], adr[w], dat[w], sel[w],
                   (win_stalls >= 0) ? win_stalls : $urandom_range(0, 2), $urandom_range(1, 3), 1'b0, 0);
        if (mask == 2'b11) begin
            l = model_pick(2'b11 & ~(w == 0 ? 2'b01 : 2'b10));
            run_access(l, we[l], adr[l], dat[l], sel[l], $urandom_range(0, 2), $urandom_range(1, 3), 1'b0, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        s_stall_i = 1'b0;
        s_ack_i   = 1'b0;
        s_err_i   = 1'b0;
        s_dat_i   = '0;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        slv_mem[32'h100] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_s_cyc", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'd0);
        check("rst_s_adr", s_adr_o, 32'd0);
        check("rst_stall", 32'({m0_stall_o, m1_stall_o}), 32'd3);
        check("rst_resp", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o}), 32'd0);
        check("rst_dat", m0_dat_o | m1_dat_o, 32'd0);
        tick();

        // Both masters contend from reset, three transfers each.
        for (int r = 0; r < 3; r++) do_round(2'b11, -1);

        // Core-only read answered two cycles after accept.
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h100, '0, 4'hF);
        run_access(model_pick(2'b01), 1'b0, 32'h100, '0, 4'hF, 0, 2, 1'b0, 0);

        // Tie with core served last: aux wins and the slave stalls it five cycles.
        do_round(2'b11, 5);

        // Watchdog: slave never answers.
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h300, '0, 4'hF);
        void'(model_pick(2'b01));
        @(negedge clk);
        check("to_gnt", 32'(gnt_o), 32'd1);
        check("to_accept", 32'(s_stb_o & ~m0_stall_o), 32'd1);
        tick();
        set_stb(0, 1'b0);
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            check("to_quiet", 32'(m0_err_o | timeout_o), 32'd0);
            check("to_cyc", 32'(s_cyc_o), 32'd1);
            tick();
        end
        @(negedge clk);
        check("to_err", 32'(m0_err_o), 32'd1);
        check("to_pulse", 32'(timeout_o), 32'd1);
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'h1234_5678;
        @(negedge clk);
        check("abort_cyc", 32'({s_cyc_o, s_stb_o}), 32'd0);
        check("abort_late_ack", 32'({m0_ack_o, m0_err_o}), 32'd0);
        check("abort_pulse_once", 32'(timeout_o), 32'd0);
        check("abort_stall", 32'(m0_stall_o), 32'd1);
        check("abort_gnt", 32'(gnt_o), 32'd1);
        check("abort_dat", m0_dat_o, 32'd0);
        tick();
        s_ack_i = 1'b0;
        s_dat_i = '0;
        set_cyc(0, 1'b0);
        @(negedge clk);
        check("abort_hold_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk);
        check("abort_idle", 32'(gnt_o), 32'd0);
        tick();

        // Slave error on an aux write is forwarded and ownership is kept.
        drive_m(1, 1'b1, 1'b1, 1'b1, 32'h204, 32'hCAFE_F00D, 4'hF);
        run_access(model_pick(2'b10), 1'b1, 32'h204, 32'hCAFE_F00D, 4'hF, 0, 1, 1'b1, 2);

        // Random traffic.
        for (int r = 0; r < 24; r++) do_round(2'($urandom_range(1, 3)), -1);

        // Reset in the middle of a core access.
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h104, '0, 4'hF);
        void'(model_pick(2'b01));
        tick();
        set_stb(0, 1'b0);
        tick();
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h200, '0, 4'hF);
        rst = 1'b1;
        last_model = 1;
        #1;
        check("mid_rst_cyc", 32'({s_cyc_o, s_stb_o}), 32'd0);
        check("mid_rst_gnt", 32'(gnt_o), 32'd0);
        s_ack_i = 1'b1;
        #1;
        check("mid_rst_ack", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        s_ack_i = 1'b0;
        #1;
        check("rst_tie", 32'(gnt_o), (model_pick(2'b11) == 0) ? 32'd1 : 32'd2);
        tick();
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("end_cyc", 32'(s_cyc_o), 32'd0);
        tick();
        @(negedge clk);
        check("end_gnt", 32'(gnt_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
